// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Optional signed support is enabled by defining SEQ_DIVIDER_SIGNED_EN.
package seq_divider_pkg;

    // Controller states. FIXUP is only entered in the signed build.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Quotient reported for a zero divisor; sliced to the dividend width by users.
    localparam logic [63:0] DBZ_QUOTIENT_ALL = '1;

    // Ceiling log2, used to size the iteration counter (must hold DIVIDEND_W).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring division step: shift the partial remainder left,
// bring in the next dividend bit, subtract the divisor when it fits.
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] shifted;

    // Trial subtraction; the remainder is restored by simply not taking the difference.
    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {2'b00, divisor});
        rem_out = q_bit ? (DIVISOR_W+1)'(shifted - {2'b00, divisor})
                        : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider, one quotient bit per clock, one operation in flight.
// Define SEQ_DIVIDER_SIGNED_EN to add the signed_mode port and the FIXUP state.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE, and the
// result outputs stay constant for as long as out_valid is high and out_ready low.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic                  signed_mode,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output state_t                dbg_state
);

    localparam int                    CNT_W        = clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0]      CNT_LOAD     = CNT_W'(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = DBZ_QUOTIENT_ALL[DIVIDEND_W-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam state_t AFTER_CALC = FIXUP;
`else
    localparam state_t AFTER_CALC = DONE;
`endif

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      count;
    logic [DIVIDEND_W-1:0] dvd_sh;
    logic [DIVIDEND_W-1:0] quo;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W:0]    prem;
    logic [DIVISOR_W:0]    prem_nxt;
    logic                  dbz;
    logic                  q_bit;
    logic                  accept;
    logic                  divisor_zero;
    logic [DIVIDEND_W-1:0] mag_dividend;
    logic [DIVISOR_W-1:0]  mag_divisor;

    assign accept       = in_valid && in_ready;
    assign divisor_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_a;
    logic neg_b;
    logic neg_q;
    logic neg_r;

    // Signed operands are divided as magnitudes; signs are reapplied in FIXUP.
    assign neg_a        = signed_mode & dividend[DIVIDEND_W-1];
    assign neg_b        = signed_mode & divisor[DIVISOR_W-1];
    assign mag_dividend = neg_a ? -dividend : dividend;
    assign mag_divisor  = neg_b ? -divisor : divisor;
`else
    assign mag_dividend = dividend;
    assign mag_divisor  = divisor;
`endif

    div_step #(
        .DIVISOR_W(DIVISOR_W)
    ) u_step (
        .rem_in  (prem),
        .bit_in  (dvd_sh[DIVIDEND_W-1]),
        .divisor (dvs),
        .rem_out (prem_nxt),
        .q_bit   (q_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CNT_W'(1)) begin
                    state_nxt = AFTER_CALC;
                end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            FIXUP: begin
                state_nxt = DONE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one restoring step per CALC cycle, sign fix-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            dvd_sh <= '0;
            dvs    <= '0;
            quo    <= '0;
            prem   <= '0;
            dbz    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        prem   <= '0;
                        dvd_sh <= mag_dividend;
                        dvs    <= mag_divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q  <= neg_a ^ neg_b;
                        neg_r  <= neg_a;
`endif
                        if (divisor_zero) begin
                            count <= '0;
                            quo   <= DBZ_QUOTIENT;
                            dbz   <= 1'b1;
                        end else begin
                            count <= CNT_LOAD;
                            quo   <= '0;
                            dbz   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    dvd_sh <= dvd_sh << 1;
                    prem   <= prem_nxt;
                    quo    <= {quo[DIVIDEND_W-2:0], q_bit};
                    count  <= count - CNT_W'(1);
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                FIXUP: begin
                    // Truncation toward zero: remainder follows the dividend's sign.
                    if (neg_q) begin
                        quo <= -quo;
                    end
                    if (neg_r) begin
                        prem <= {1'b0, -prem[DIVISOR_W-1:0]};
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign quotient    = quo;
    assign remainder   = prem[DIVISOR_W-1:0];
    assign div_by_zero = dbz;
    assign dbg_state   = state;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model with a
// transaction-level timing model, per-cycle compare, plus literal expectations.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int DW = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
    // +9 needs five bits as a signed divisor.
    localparam int SW        = 5;
    localparam int EXTRA_LAT = 1;
`else
    localparam int SW        = 4;
    localparam int EXTRA_LAT = 0;
`endif
    localparam int RW  = DW + SW + 1;
    localparam int LAT = DW + EXTRA_LAT;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          signed_mode = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;
    state_t        dbg_state;

    seq_divider #(
        .DIVIDEND_W(DW),
        .DIVISOR_W (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    int   checks   = 0;
    int   failures = 0;
    logic check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Result packed as {quotient, remainder, div_by_zero}.
    function automatic logic [RW-1:0] model_div(input logic [DW-1:0] a,
                                                input logic [SW-1:0] b,
                                                input logic          sm);
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        int            sa;
        int            sb;
        if (b == '0) begin
            return {{DW{1'b1}}, {SW{1'b0}}, 1'b1};
        end
        if (sm) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = DW'(sa / sb);
            r  = SW'(sa % sb);
        end else begin
            q  = a / DW'(b);
            r  = SW'(a % DW'(b));
        end
        return {q, r, 1'b0};
    endfunction

    // Transaction-level timing: busy from accept to result handshake, result
    // visible once the latency countdown expires.
    logic          m_busy = 1'b0;
    int            m_cnt  = 0;
    logic [RW-1:0] exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_cnt  = (divisor == '0) ? 0 : LAT;
                exp_q.push_back(model_div(dividend, divisor, signed_mode));
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (out_ready) begin
            m_busy = 1'b0;
            void'(exp_q.pop_front());
        end
    end

    // ---------------- scoreboard compare ----------------
    logic          cmp_valid;
    logic [RW-1:0] cmp_e;

    always @(negedge clk) begin
        if (check_en && !rst) begin
            cmp_valid = m_busy && (m_cnt == 0);
            chk("in_ready", in_ready, !m_busy);
            chk("out_valid", out_valid, cmp_valid);
            if (cmp_valid) begin
                if (exp_q.size() != 1) begin
                    chk("exp_q_size", exp_q.size(), 1);
                end else begin
                    cmp_e = exp_q[0];
                    chk("quotient", quotient, cmp_e[RW-1 -: DW]);
                    chk("remainder", remainder, cmp_e[SW:1]);
                    chk("div_by_zero", div_by_zero, cmp_e[0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1. Presents one operation, scrambles operands after the
    // accept edge, checks latency (edges after the accept edge) and literal
    // results, optionally stalls the consumer for 'hold' cycles.
    task automatic do_op(input logic [DW-1:0] a, input logic [SW-1:0] b, input logic sm,
                         input logic [DW-1:0] eq, input logic [SW-1:0] er, input logic ed,
                         input int elat, input int hold);
        int lat;
        out_ready   = (hold == 0);
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        in_valid    = 1'b1;
        chk("accept_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        dividend    = DW'($urandom_range(0, 255));
        divisor     = SW'($urandom_range(0, (1 << SW) - 1));
        signed_mode = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, elat);
        chk("quotient_lit", quotient, eq);
        chk("remainder_lit", remainder, er);
        chk("dbz_lit", div_by_zero, ed);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_quotient", quotient, eq);
            chk("hold_remainder", remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", out_valid, 1'b0);
        chk("release_ready", in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        check_en = 1'b1;
        chk("reset_state", dbg_state, IDLE);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dbz", div_by_zero, 1'b0);

        do_op(8'd32, SW'(5), 1'b0, 8'd6, SW'(2), 1'b0, LAT, 0);
        // back-to-back with out_ready held high
        do_op(8'd73, SW'(9), 1'b0, 8'd8, SW'(1), 1'b0, LAT, 0);
        do_op(8'd255, SW'(15), 1'b0, 8'd17, SW'(0), 1'b0, LAT, 0);
        // zero divisor: result visible right after the accept edge
        do_op(8'd200, SW'(0), 1'b0, 8'hFF, SW'(0), 1'b1, 0, 0);
        // consumer stall
        do_op(8'd7, SW'(15), 1'b0, 8'd0, SW'(7), 1'b0, LAT, 5);

        // reset in the middle of CALC aborts the operation
        dividend    = 8'd100;
        divisor     = SW'(3);
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_calc_state", dbg_state, CALC);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_state", dbg_state, IDLE);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 1'b0);
        do_op(8'd100, SW'(3), 1'b0, 8'd33, SW'(1), 1'b0, LAT, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        // -73 / 9 = -8 r -1 ; -128 / -1 wraps to -128 r 0
        do_op(8'hB7, SW'(9), 1'b1, 8'hF8, 5'h1F, 1'b0, LAT, 0);
        do_op(8'h80, 5'h1F, 1'b1, 8'h80, SW'(0), 1'b0, LAT, 0);
        // 9 / -4 = -2 r 1
        do_op(8'd9, 5'h1C, 1'b1, 8'hFE, SW'(1), 1'b0, LAT, 0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
